// File: rtl/hermes_buffer.sv
// Hermes router input buffer: a FLIT_SIZE x BUFFER_SIZE FIFO followed by a
// packet-forwarding FSM. The FSM requests a route for the packet at the FIFO
// head, then streams header, size and payload flits downstream.
//
// Handshakes:
//   upstream   - a flit is written on a rising clk_i edge when rx_i && credit_o;
//                credit_o is high whenever the FIFO has a free slot.
//   downstream - a flit is read on a rising clk_i edge when tx_o && credit_i;
//                data_o always shows the FIFO head, tx_o marks it as valid.
//   routing    - req_o holds high until ack_i is sampled high; ack_i outside
//                the request phase has no effect.
module hermes_buffer #(
  parameter int FLIT_SIZE   = 32,  // at least 20
  parameter int BUFFER_SIZE = 8    // power of two, at least 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 credit_o,
  output logic                 req_o,
  input  logic                 ack_i,
  output logic                 sending_o,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic [2:0]           state_o     // debug view of the forwarding FSM
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(BUFFER_SIZE);
  localparam logic [FLIT_SIZE-1:0] FLIT_ONE = FLIT_SIZE'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    HEADER  = 3'd2,
    SIZE    = 3'd3,
    PAYLOAD = 3'd4,
    END     = 3'd5
  } state_t;

  logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;

  state_t               state_q;
  logic                 req_q;
  logic                 sending_q;
  logic [FLIT_SIZE-1:0] rem_q;

  logic wr_en;
  logic rd_en;
  logic fifo_nempty;
  logic fwd_state;

  // Datapath strobes and combinational views of the registered state.
  always_comb begin
    fifo_nempty = (count_q != '0);
    fwd_state   = (state_q == HEADER) || (state_q == SIZE) || (state_q == PAYLOAD);
    credit_o    = (count_q < CNT_FULL);
    tx_o        = fwd_state && fifo_nempty;
    wr_en       = rx_i && credit_o;
    rd_en       = tx_o && credit_i;
  end

  // The head is shown straight from storage; a new write into an empty FIFO
  // only appears on data_o once it has been stored (no bypass path).
  assign data_o    = mem_q[rd_ptr_q];
  assign req_o     = req_q;
  assign sending_o = sending_q;
  assign state_o   = state_q;

  // FIFO storage, pointers and occupancy. Pointers are PTR_W bits wide, so
  // incrementing past BUFFER_SIZE-1 wraps to 0 on its own.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUFFER_SIZE; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      // A simultaneous read and write leaves occupancy untouched.
      if (wr_en && !rd_en) begin
        count_q <= count_q + CNT_ONE;
      end else if (!wr_en && rd_en) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Packet forwarding FSM with registered req/sending outputs. Every
  // forwarding state advances only on a read, so an empty FIFO or a
  // withheld credit_i simply holds the current state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      sending_q <= 1'b0;
      rem_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fifo_nempty) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          if (ack_i) begin
            state_q   <= HEADER;
            req_q     <= 1'b0;
            sending_q <= 1'b1;
          end
        end
        HEADER: begin
          if (rd_en) begin
            state_q <= SIZE;
          end
        end
        SIZE: begin
          if (rd_en) begin
            rem_q <= data_o;
            if (data_o != '0) begin
              state_q <= PAYLOAD;
            end else begin
              state_q   <= END;
              sending_q <= 1'b0;
            end
          end
        end
        PAYLOAD: begin
          if (rd_en) begin
            rem_q <= rem_q - FLIT_ONE;
            if (rem_q == FLIT_ONE) begin
              state_q   <= END;
              sending_q <= 1'b0;
            end
          end
        end
        END: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          req_q     <= 1'b0;
          sending_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hermes_buffer.sv
// Directed testbench for hermes_buffer: each task drives one scenario and
// compares the observed outputs against hand-computed values.
module tb_hermes_buffer;

  localparam int FW = 32;
  localparam int BS = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_REQ     = 3'd1;
  localparam logic [2:0] ST_HEADER  = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_END     = 3'd5;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          rx        = 1'b0;
  logic          ack       = 1'b0;
  logic          credit_in = 1'b0;
  logic [FW-1:0] din       = '0;
  logic          credit_out;
  logic          req;
  logic          sending;
  logic          tx;
  logic [FW-1:0] dout;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rd_cyc = 0;

  logic [FW-1:0] got_q[$];
  logic [FW-1:0] exp_q[$];

  hermes_buffer #(.FLIT_SIZE(FW), .BUFFER_SIZE(BS)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rx_i      (rx),
    .data_i    (din),
    .credit_o  (credit_out),
    .req_o     (req),
    .ack_i     (ack),
    .sending_o (sending),
    .tx_o      (tx),
    .data_o    (dout),
    .credit_i  (credit_in),
    .state_o   (state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Downstream monitor: records every flit taken on a read edge.
  always @(posedge clk) begin
    cyc++;
    if (tx && credit_in) begin
      got_q.push_back(dout);
      last_rd_cyc = cyc;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic write_packet();
    rx = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      din = exp_q[i];
      tick();
    end
    rx  = 1'b0;
    din = '0;
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b0; ack = 1'b0; credit_in = 1'b0; din = '0;
    repeat (2) tick();
    checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL reset_credit: got %b want 1", credit_out); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if (sending !== 1'b0) begin errors++; $display("FAIL reset_sending: got %b want 0", sending); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL reset_tx: got %b want 0", tx); end
    checks++; if (dout !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", dout); end
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (state !== ST_IDLE || req !== 1'b0) begin errors++; $display("FAIL idle_empty: state %0d req %b want 0/0", state, req); end
  endtask

  task automatic test_basic_packet();
    bit ok;
    int n_send, n_end, fall_cyc;
    got_q.delete();
    exp_q = '{32'h0000_0101, 32'h2, 32'hA, 32'hB};
    credit_in = 1'b1;
    rx = 1'b1; din = exp_q[0];
    checks++; if (dout !== '0) begin errors++; $display("FAIL no_bypass: got %h want 0", dout); end
    tick();
    checks++; if (dout !== 32'h0000_0101) begin errors++; $display("FAIL head_visible: got %h want 00000101", dout); end
    din = exp_q[1]; tick();
    din = exp_q[2]; tick();
    din = exp_q[3]; tick();
    rx = 1'b0; din = '0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_req_rise: req never rose"); end
    tick(); tick();
    checks++; if (req !== 1'b1 || tx !== 1'b0) begin errors++; $display("FAIL basic_req_hold: req %b tx %b want 1/0", req, tx); end
    pulse_ack();
    checks++; if (req !== 1'b0 || sending !== 1'b1 || state !== ST_HEADER) begin
      errors++; $display("FAIL basic_grant: req %b sending %b state %0d want 0/1/%0d", req, sending, state, ST_HEADER);
    end
    n_send = 1; n_end = 0; fall_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sending === 1'b1) n_send++;
      else if (fall_cyc < 0) fall_cyc = cyc;
      if (state === ST_END) n_end++;
    end
    checks++; if (n_send != 4) begin errors++; $display("FAIL basic_sending_cycles: got %0d want 4", n_send); end
    checks++; if (n_end != 1) begin errors++; $display("FAIL basic_end_cycles: got %0d want 1", n_end); end
    checks++; if (fall_cyc != last_rd_cyc) begin errors++; $display("FAIL basic_sending_fall: fell at %0d, last read at %0d", fall_cyc, last_rd_cyc); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d flits want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_ack_in_idle();
    ack = 1'b1;
    tick(); tick();
    ack = 1'b0;
    tick();
    checks++; if (state !== ST_IDLE || req !== 1'b0 || sending !== 1'b0) begin
      errors++; $display("FAIL idle_ack: state %0d req %b sending %b want 0/0/0", state, req, sending);
    end
  endtask

  task automatic test_full_and_stall();
    bit bad;
    got_q.delete();
    exp_q = '{32'h0000_0202, 32'd6, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66};
    credit_in = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 8; i++) begin
      din = exp_q[i];
      tick();
      if (i == 6) begin
        checks++; if (credit_out !== 1'b1) begin errors++; $display("FAIL full_credit7: got %b want 1", credit_out); end
      end
    end
    rx = 1'b0;
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL full_credit8: got %b want 0", credit_out); end
    rx = 1'b1; din = 32'hDEAD_BEEF; tick();
    rx = 1'b0; din = '0;
    checks++; if (credit_out !== 1'b0) begin errors++; $display("FAIL full_drop: credit %b want 0", credit_out); end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (req !== 1'b1 || tx !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin errors++; $display("FAIL ack_wait: req/tx left 1/0 while waiting for ack"); end
    credit_in = 1'b1;
    pulse_ack();
    repeat (20) tick();
    checks++; if (credit_out !== 1'b1 || state !== ST_IDLE) begin errors++; $display("FAIL full_drain: credit %b state %0d want 1/0", credit_out, state); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL full_count: got %0d flits want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_zero_size();
    bit ok, saw_payload;
    int n_send, n_end;
    got_q.delete();
    exp_q = '{32'h0000_0303, 32'h0};
    credit_in = 1'b1;
    write_packet();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_req_rise: req never rose"); end
    pulse_ack();
    n_send = (sending === 1'b1) ? 1 : 0;
    n_end = 0; saw_payload = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sending === 1'b1) n_send++;
      if (state === ST_END) n_end++;
      if (state === ST_PAYLOAD) saw_payload = 1'b1;
    end
    checks++; if (n_send != 2) begin errors++; $display("FAIL zero_sending_cycles: got %0d want 2", n_send); end
    checks++; if (n_end != 1 || saw_payload) begin errors++; $display("FAIL zero_path: end cycles %0d payload %b want 1/0", n_end, saw_payload); end
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL zero_count: got %0d flits want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL zero_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_credit_toggle();
    bit ok, req_glitch;
    int b, end_cyc, rise_cyc;
    got_q.delete();
    exp_q = '{32'h0000_0404, 32'd5, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45,
              32'h0000_0505, 32'd1, 32'h51};
    credit_in = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = exp_q[i];
      tick();
    end
    rx = 1'b0; din = '0;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL toggle_req_rise: req never rose"); end
    pulse_ack();
    b = 7; end_cyc = -1; rise_cyc = -1; req_glitch = 1'b0;
    for (int i = 0; i < 40; i++) begin
      credit_in = ~credit_in;
      if (b < 10 && credit_out === 1'b1) begin
        rx = 1'b1; din = exp_q[b]; b++;
      end else begin
        rx = 1'b0; din = '0;
      end
      tick();
      if (state === ST_END && end_cyc < 0) end_cyc = cyc;
      if (req === 1'b1 && rise_cyc < 0) begin
        rise_cyc = cyc;
        if (end_cyc < 0) req_glitch = 1'b1;
      end
    end
    rx = 1'b0; din = '0; credit_in = 1'b1;
    checks++; if (b != 10) begin errors++; $display("FAIL toggle_writes: wrote %0d flits want 10", b); end
    checks++; if (req_glitch || end_cyc < 0 || rise_cyc != end_cyc + 2) begin
      errors++; $display("FAIL toggle_req_after_end: req rose at %0d, END at %0d", rise_cyc, end_cyc);
    end
    checks++; if (state !== ST_REQ) begin errors++; $display("FAIL toggle_second_req: state %0d want %0d", state, ST_REQ); end
    pulse_ack();
    repeat (12) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL toggle_count: got %0d flits want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit ok, seen;
    got_q.delete();
    exp_q = '{32'h0000_0606, 32'd4, 32'h71, 32'h72, 32'h73, 32'h74};
    credit_in = 1'b1;
    write_packet();
    wait_req(ok);
    pulse_ack();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (state === ST_PAYLOAD) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_reach_payload: state %0d", state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (credit_out !== 1'b1 || req !== 1'b0 || sending !== 1'b0 || tx !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: credit %b req %b sending %b tx %b want 1/0/0/0", credit_out, req, sending, tx);
    end
    checks++; if (dout !== '0 || state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: data %h state %0d want 0/0", dout, state); end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    checks++; if (state !== ST_IDLE || req !== 1'b0 || tx !== 1'b0) begin
      errors++; $display("FAIL midrst_no_residual: state %0d req %b tx %b want 0/0/0", state, req, tx);
    end
    got_q.delete();
    exp_q = '{32'h0000_0707, 32'd1, 32'h77};
    write_packet();
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_req_rise: req never rose"); end
    pulse_ack();
    repeat (10) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midrst_count: got %0d flits want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_flit%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_packet();
    test_ack_in_idle();
    test_full_and_stall();
    test_zero_size();
    test_credit_toggle();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hermes_buffer.md
HERMES_BUFFER -- requirements
Module: hermes_buffer

Interface
REQ-001 Parameter: FLIT_SIZE, 32, flit width in bits; minimum 20.
REQ-002 Parameter: BUFFER_SIZE, 8, FIFO depth in flits; power of two, minimum 4.
REQ-003 Port: clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst_ni  input  1  asynchronous, active-low reset.
REQ-005 Port: rx_i  input  1  upstream flit valid.
REQ-006 Port: data_i  input  FLIT_SIZE  upstream flit.
REQ-007 Port: credit_o  output  1  buffer can accept a flit (not full).
REQ-008 Port: req_o  output  1  routing request to switch control.
REQ-009 Port: ack_i  input  1  routing grant from switch control.
REQ-010 Port: sending_o  output  1  packet forwarding in progress; a falling edge frees the output port.
REQ-011 Port: tx_o  output  1  downstream flit valid.
REQ-012 Port: data_o  output  FLIT_SIZE  flit at FIFO head.
REQ-013 Port: credit_i  input  1  downstream can accept a flit.

Function
REQ-014 Packet format SHALL be: header flit (target in [15:0]), then size flit (N = payload flit count, unsigned FLIT_SIZE bits), then N payload flits.
REQ-015 Write SHALL occur when rx_i && credit_o; read SHALL occur when tx_o && credit_i.
REQ-016 credit_o SHALL be 1 iff occupancy < BUFFER_SIZE; occupancy counter width SHALL be clog2(BUFFER_SIZE)+1.
REQ-017 Simultaneous read and write SHALL leave occupancy unchanged.
REQ-018 Read and write pointers SHALL wrap from BUFFER_SIZE-1 to 0.
REQ-019 A write into an empty FIFO SHALL have no bypass; the flit SHALL become visible on data_o the next cycle.
REQ-020 data_o SHALL always present the flit at the read pointer.
REQ-021 FSM states SHALL be IDLE, REQ, HEADER, SIZE, PAYLOAD, END.
REQ-022 IDLE -> REQ when occupancy > 0; otherwise the FSM SHALL stay in IDLE.
REQ-023 In REQ, req_o SHALL be 1 until ack_i is sampled high; then the next state SHALL be HEADER and req_o SHALL be 0 from that cycle on.
REQ-024 ack_i in any state other than REQ SHALL be ignored.
REQ-025 sending_o SHALL be 1 in HEADER, SIZE and PAYLOAD, and 0 in all other states.
REQ-026 tx_o SHALL be 1 iff the state is HEADER, SIZE or PAYLOAD and occupancy > 0.
REQ-027 HEADER -> SIZE on a read.
REQ-028 On a read in SIZE, the remaining counter SHALL load data_o.
REQ-029 SIZE -> PAYLOAD on a read if data_o != 0; SIZE -> END on a read if data_o == 0.
REQ-030 In PAYLOAD, each read SHALL decrement the remaining counter; the read with remaining counter == 1 SHALL go to END.
REQ-031 END SHALL last exactly one cycle with sending_o = 0, then -> IDLE.
REQ-032 An empty FIFO or credit_i = 0 during forwarding SHALL stall the FSM without leaving its state.
REQ-033 Upstream writes SHALL continue in every state, including writes of the next packet's flits during forwarding.

Reset
REQ-034 With rst_ni = 0, asynchronously: state = IDLE, pointers = 0, occupancy = 0, remaining counter = 0, and all FIFO entries = 0.
REQ-035 Reset output values SHALL be: credit_o = 1, req_o = 0, sending_o = 0, tx_o = 0, data_o = 0.
REQ-036 Reset asserted mid-packet SHALL discard all buffered flits, and the FSM SHALL restart from IDLE with no residual request.

Verification
REQ-037 Scenario: reset, then write 0x0000_0101, 0x2, 0xA, 0xB; ack_i pulse 2 cycles after req_o rises; credit_i = 1 -> tx_o emits exactly 4 flits in order; sending_o falls the cycle after 0xB is read; END lasts 1 cycle.
REQ-038 Scenario: write 8 flits with credit_i = 0 -> credit_o = 0 after the 8th write; a 9th rx_i pulse is dropped; occupancy stays 8.
REQ-039 Scenario: header plus size = 0 -> 2 flits forwarded; SIZE -> END; sending_o high for exactly 2 cycles with credit_i = 1.
REQ-040 Scenario: ack_i held 0 for 20 cycles -> req_o stays 1 and tx_o stays 0; ack_i pulsed while in IDLE -> no state change.
REQ-041 Scenario: toggle credit_i every cycle during a 5-payload packet while writing a second packet -> no flit lost or duplicated; the second packet's req_o rises after END.
REQ-042 Scenario: rst_ni low during PAYLOAD -> outputs take reset values immediately; post-reset, a new packet forwards correctly.
